// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit for the 8-bit core: fetch/decode/execute sequencing,
// instruction register, PC and the load-data register feeding the datapath.
module cpu_ctrl_fsm (
   input  logic        clk,
   input  logic        rst_n,
   output logic [7:0]  imem_addr,
   input  logic [15:0] imem_rdata,
   output logic [7:0]  dmem_addr,
   output logic        dmem_re,
   output logic        dmem_we,
   input  logic        dmem_ready,
   input  logic [7:0]  dmem_rdata,
   output logic [7:0]  mem_data,
   output logic [1:0]  Rs,
   output logic [1:0]  Rt,
   output logic [1:0]  Rd,
   output logic [7:0]  imm,
   output logic        selscrB,
   output logic        regdes,
   output logic        memtoreg,
   output logic [2:0]  alucs,
   output logic        regwrite,
   output logic        flagwrite,
   input  logic        zeroout,
   output logic        halted,
   // Debug view of the FSM: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT.
   output logic [2:0]  state_dbg
);

   // Data-memory handshake: dmem_re/dmem_we act as valid and dmem_ready as ready.
   // The access completes in the cycle both are high; until then the strobe stays
   // high and dmem_addr stays unchanged. Nothing is retained across a reset.

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_ADC  = 4'h6;
   localparam logic [3:0] OP_ADDI = 4'h7;
   localparam logic [3:0] OP_LDI  = 4'h8;
   localparam logic [3:0] OP_LD   = 4'h9;
   localparam logic [3:0] OP_ST   = 4'hA;
   localparam logic [3:0] OP_BEQZ = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t      state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [7:0]  mem_data_q, mem_data_d;
   logic [3:0]  op;
   logic        op_alu;
   logic        op_regw;
   logic        op_flagw;
   logic [7:0]  pc_inc;

   assign op       = ir_q[15:12];
   assign op_alu   = (op >= OP_ADD) && (op <= OP_ADC);
   assign op_regw  = (op >= OP_ADD) && (op <= OP_LD);
   assign op_flagw = (op >= OP_ADD) && (op <= OP_ADDI);
   assign pc_inc   = pc_q + 8'd1;

   // Field decode comes straight from IR, so it is stable from EXEC to end of WB.
   assign imem_addr = pc_q;
   assign dmem_addr = ir_q[7:0];
   assign imm       = ir_q[7:0];
   assign Rs        = ir_q[11:10];
   assign Rt        = ir_q[9:8];
   assign Rd        = ir_q[7:6];
   assign mem_data  = mem_data_q;
   assign halted    = (state_q == S_HALT);
   assign state_dbg = state_q;

   always_comb begin
      alucs    = 3'b000;
      selscrB  = 1'b0;
      regdes   = 1'b0;
      memtoreg = 1'b0;
      case (op)
         OP_ADD:  alucs = 3'b000;
         OP_SUB:  alucs = 3'b001;
         OP_AND:  alucs = 3'b010;
         OP_OR:   alucs = 3'b011;
         OP_XOR:  alucs = 3'b100;
         OP_ADC:  alucs = 3'b101;
         OP_ADDI: selscrB = 1'b1;
         OP_LDI: begin
            alucs   = 3'b111;
            selscrB = 1'b1;
         end
         OP_LD: begin
            selscrB  = 1'b1;
            memtoreg = 1'b1;
         end
         OP_ST: begin
            alucs   = 3'b110;
            selscrB = 1'b1;
         end
         default: alucs = 3'b000;
      endcase
      regdes = op_alu;
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      mem_data_d = mem_data_q;
      dmem_re    = 1'b0;
      dmem_we    = 1'b0;
      regwrite   = 1'b0;
      flagwrite  = 1'b0;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            ir_d    = imem_rdata;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            case (op)
               OP_LD, OP_ST: state_d = S_MEM;
               OP_BEQZ: begin
                  pc_d    = zeroout ? ir_q[7:0] : pc_inc;
                  state_d = S_FETCH;
               end
               OP_JMP: begin
                  pc_d    = ir_q[7:0];
                  state_d = S_FETCH;
               end
               OP_HALT: state_d = S_HALT;
               default: begin
                  // NOP and the unused opcodes D/E fall through to the next word.
                  if (op_regw) begin
                     state_d = S_WB;
                  end else begin
                     pc_d    = pc_inc;
                     state_d = S_FETCH;
                  end
               end
            endcase
         end
         S_MEM: begin
            dmem_re = (op == OP_LD);
            dmem_we = (op == OP_ST);
            if (dmem_ready) begin
               if (op == OP_LD) begin
                  mem_data_d = dmem_rdata;
               end
               state_d = S_WB;
            end
         end
         S_WB: begin
            regwrite  = op_regw;
            flagwrite = op_flagw;
            pc_d      = pc_inc;
            state_d   = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         pc_q       <= 8'h00;
         ir_q       <= 16'h0000;
         mem_data_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         mem_data_q <= mem_data_d;
      end
   end

endmodule

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port imem_addr, output, 8 bits: instruction address, equal to the PC.
REQ-004 SHALL have port imem_rdata, input, 16 bits: instruction word, valid one cycle after imem_addr is stable (synchronous ROM).
REQ-005 SHALL have port dmem_addr, output, 8 bits: data address, equal to IR[7:0].
REQ-006 SHALL have ports dmem_re and dmem_we, outputs, 1 bit each: data read and write strobes.
REQ-007 SHALL have port dmem_ready, input, 1 bit: data memory completes the access in the current cycle.
REQ-008 SHALL have port dmem_rdata, input, 8 bits: read data, valid when dmem_ready=1.
REQ-009 SHALL have port mem_data, output, 8 bits: registered load data for the datapath memData input.
REQ-010 SHALL have ports Rs, Rt and Rd, outputs, 2 bits each: register selects, equal to IR[11:10], IR[9:8] and IR[7:6].
REQ-011 SHALL have port imm, output, 8 bits: immediate, equal to IR[7:0].
REQ-012 SHALL have ports selscrB, regdes and memtoreg, outputs, 1 bit each: datapath mux selects.
REQ-013 SHALL have port alucs, output, 3 bits: ALU operation code.
REQ-014 SHALL have ports regwrite and flagwrite, outputs, 1 bit each: write enables, each a one-cycle pulse.
REQ-015 SHALL have port zeroout, input, 1 bit: zero flag register from the datapath.
REQ-016 SHALL have port halted, output, 1 bit: the core is stopped by HALT.

Function
REQ-017 SHALL decode opcode IR[15:12] as follows:
- 0 = NOP.
- 1-6 = ADD, SUB, AND, OR, XOR, ADC (Rd <- Rs op Rt).
- 7 = ADDI (Rt <- Rs + imm).
- 8 = LDI (Rt <- imm).
- 9 = LD (Rt <- mem[imm]).
- A = ST (mem[imm] <- Rs).
- B = BEQZ (PC <- imm if zeroout=1).
- C = JMP (PC <- imm).
- D and E = illegal, executed as NOP.
- F = HALT.
REQ-018 SHALL drive alucs with this encoding:
- 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 ADC.
- 110 PASSA for ST.
- 111 PASSB for LDI.
- 000 for all other opcodes.
REQ-019 SHALL drive the mux selects as follows:
- selscrB=1 for ADDI, LDI, LD and ST, otherwise 0.
- regdes=1 for opcodes 1-6, otherwise 0.
- memtoreg=1 only for LD.
REQ-020 SHALL run a state machine with states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-021 SHALL perform FETCH: drive imem_addr=PC, then go to DECODE.
REQ-022 SHALL perform DECODE: latch IR <= imem_rdata, then go to EXEC.
REQ-023 SHALL leave EXEC as follows:
- LD and ST go to MEM.
- BEQZ, JMP, NOP and illegal opcodes update the PC and go to FETCH.
- HALT goes to HALT.
- All other opcodes go to WB.
REQ-024 SHALL hold dmem_re (LD) or dmem_we (ST) high in MEM until dmem_ready=1, staying in MEM while dmem_ready=0.
REQ-025 SHALL, on dmem_ready in MEM, latch mem_data <= dmem_rdata for LD, then go to WB.
REQ-026 SHALL perform WB: pulse regwrite for opcodes 1-9; pulse flagwrite for opcodes 1-7; PC <= PC+1; go to FETCH.
REQ-027 SHALL, for ST, assert no regwrite or flagwrite in WB but still increment the PC.
REQ-028 SHALL wrap the PC from 0xFF to 0x00 on increment.
REQ-029 SHALL resolve BEQZ using the zeroout value sampled in EXEC.
REQ-030 SHALL hold all decoded outputs stable from EXEC through the end of WB.
REQ-031 SHALL, in HALT, set halted=1, hold all strobes at 0 and keep the PC; only reset exits HALT.
REQ-032 SHALL take cycle counts as follows:
- ALU, ADDI and LDI instructions: 4 cycles.
- LD and ST: 5 cycles plus dmem wait cycles.
- BEQZ, JMP and NOP: 3 cycles.

Reset
REQ-033 SHALL, on rst_n=0, immediately set the state to FETCH and clear the following:
- PC, IR and mem_data all = 0.
- regwrite, flagwrite, dmem_re, dmem_we and halted all = 0.
REQ-034 SHALL, on reset asserted mid-MEM, drop dmem_we and dmem_re asynchronously, with no write pulse completed.
REQ-035 SHALL fetch address 0x00 in the first cycle after rst_n deasserts.

Verification
REQ-036 SHALL cover LDI: ROM[0]=0x8105 -> regwrite pulse in cycle 4, Rt=1, alucs=111, selscrB=1; PC=0x01.
REQ-037 SHALL cover ADD: ROM word 0x1140 (Rd=1, Rs=0, Rt=1) -> regdes=1, alucs=000, regwrite and flagwrite pulse together in WB.
REQ-038 SHALL cover LD with wait: LD 0x20 with dmem_ready low for 2 cycles -> dmem_re high for 3 cycles, mem_data=dmem_rdata, memtoreg=1, regwrite in the following cycle.
REQ-039 SHALL cover BEQZ both ways: zeroout=1 gives PC=imm after 3 cycles; zeroout=0 gives PC+1, with no regwrite or flagwrite either way.
REQ-040 SHALL cover PC wrap and HALT: NOP at 0xFF -> next fetch at 0x00; HALT -> halted=1, PC frozen for 10 cycles.
REQ-041 SHALL cover reset during ST: ST in MEM with dmem_ready=0, then rst_n=0 -> dmem_we=0 the same cycle, PC=0, state FETCH.
